// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and helpers for the multiply/divide unit.
package muldiv_pkg;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int ITER_COUNT = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_divstep.sv
// muldiv_divstep: one combinational restoring-division step (shift in next dividend bit, trial subtract).
module muldiv_divstep #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] sh, diff;
  logic ge;
  assign sh = {rem_i, quo_i[WIDTH-1]};
  assign ge = sh >= {1'b0, div_i};
  assign diff = sh - {1'b0, div_i};
  assign rem_o = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ge};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiply (IDLE -> FIX).
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  // a_q holds {partial, multiplier} for multiply and {remainder, quotient} for divide
  logic [2*WIDTH-1:0] a_q, a_d, prod;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, m1, m2, rem_n, quo_n;
  logic [WIDTH:0] msum;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic busy_q, done_q, done_d, dzp_q, dzp_d;

  muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i(a_q[2*WIDTH-1:WIDTH]),
    .quo_i(a_q[WIDTH-1:0]),
    .div_i(b_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );

  assign m1 = mag(in1, op[0]);
  assign m2 = mag(in2, op[0]);
  assign msum = {1'b0, a_q[2*WIDTH-1:WIDTH]} + (a_q[0] ? {1'b0, b_q} : '0);
  assign prod = neg_q ? -a_q : a_q;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    div_d = div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dzp_d = 1'b0;
    case (state_q)
      IDLE: begin
        hi_d = mthi ? in1 : hi_q;
        lo_d = mtlo ? in1 : lo_q;
        if (start) begin
          div_d = op[1];
          neg_d = op[0] && (in1[WIDTH-1] ^ in2[WIDTH-1]);
          rneg_d = op[0] && in1[WIDTH-1];
          dz_d = 1'b0;
          cnt_d = '0;
          a_d = {{WIDTH{1'b0}}, m1};
          b_d = m2;
          state_d = CALC;
          if (op[1] && in2 == '0) begin
            a_d = {in1, DIV0_QUOT};
            neg_d = 1'b0;
            rneg_d = 1'b0;
            dz_d = 1'b1;
            state_d = FIX;
          end
`ifdef MULDIV_FAST_MULT_EN
          if (!op[1]) begin
            a_d = (2*WIDTH)'(m1) * (2*WIDTH)'(m2);
            state_d = FIX;
          end
`else
`endif
        end
      end
      CALC: begin
        a_d = div_q ? {rem_n, quo_n} : {msum, a_q[WIDTH-1:1]};
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'(ITER_COUNT - 1)) ? FIX : CALC;
      end
      FIX: begin
        hi_d = !div_q ? prod[2*WIDTH-1:WIDTH] : rneg_q ? -a_q[2*WIDTH-1:WIDTH] : a_q[2*WIDTH-1:WIDTH];
        lo_d = !div_q ? prod[WIDTH-1:0] : neg_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        done_d = 1'b1;
        dzp_d = dz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dzp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      div_q <= div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= state_d != IDLE;
      done_q <= done_d;
      dzp_q <= dzp_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div_by_zero = dzp_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
